// File: rtl/fault_detector.sv
// fault_detector
// Lockstep checker comparing a reference ALU against a DUT ALU. Every cycle
// it can accept one golden/faulty result pair. It counts accepted samples and
// mismatches, captures details of the first fault, and requests a halt once
// THRESH mismatches have been seen.
//
// Handshake: there is no backpressure. A sample is consumed in the cycle where
// sample_valid=1, enable=1, clear=0, and the FSM is in MONITOR or DETECTED.
// At any other time the sample is dropped.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   enable              monitoring enable (IDLE->MONITOR, gates acceptance)
//   clear               synchronous soft clear back to IDLE
//   sample_valid        golden/faulty pair present this cycle
//   golden_*/faulty_*   result (32), zero flag (1), ALU control (3)
//   mismatch            one-cycle pulse per accepted mismatching sample
//   fault_detected      sticky first-fault flag
//   halt_req            high while in HALT
//   state               IDLE=00 MONITOR=01 DETECTED=10 HALT=11 (debug/status)
//   sample_count        accepted samples (wraps)
//   mismatch_count      accepted mismatches (saturates at 255)
//   first_*             capture of the first fault
//   fault_class         00 none, 01 data, 10 control, 11 both
module fault_detector #(
    parameter int THRESH = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             sample_valid,
    input  logic [31:0]      golden_result,
    input  logic [31:0]      faulty_result,
    input  logic             golden_zero,
    input  logic             faulty_zero,
    input  logic [2:0]       golden_ctrl,
    input  logic [2:0]       faulty_ctrl,
    output logic             mismatch,
    output logic             fault_detected,
    output logic             halt_req,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] sample_count,
    output logic [7:0]       mismatch_count,
    output logic [CNT_W-1:0] first_index,
    output logic [31:0]      first_golden,
    output logic [31:0]      first_faulty,
    output logic [31:0]      first_syndrome,
    output logic [1:0]       fault_class
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_MONITOR  = 2'b01,
        S_DETECTED = 2'b10,
        S_HALT     = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic             mismatch_q, mismatch_d;
    logic             fault_detected_q, fault_detected_d;
    logic             halt_req_q, halt_req_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic [7:0]       mismatch_count_q, mismatch_count_d;
    logic [CNT_W-1:0] first_index_q, first_index_d;
    logic [31:0]      first_golden_q, first_golden_d;
    logic [31:0]      first_faulty_q, first_faulty_d;
    logic [31:0]      first_syndrome_q, first_syndrome_d;
    logic [1:0]       fault_class_q, fault_class_d;

    logic       data_mis;
    logic       ctrl_mis;
    logic       accept;
    logic [7:0] mcount_inc;

    assign data_mis = (golden_result != faulty_result) || (golden_zero != faulty_zero);
    assign ctrl_mis = (golden_ctrl != faulty_ctrl);

    // clear outranks acceptance, so it is folded into the accept term here.
    assign accept = sample_valid && enable && !clear &&
                    ((state_q == S_MONITOR) || (state_q == S_DETECTED));

    assign mcount_inc = (mismatch_count_q == 8'hFF) ? 8'hFF : mismatch_count_q + 8'd1;

    always_comb begin
        state_d          = state_q;
        mismatch_d       = 1'b0;
        fault_detected_d = fault_detected_q;
        sample_count_d   = sample_count_q;
        mismatch_count_d = mismatch_count_q;
        first_index_d    = first_index_q;
        first_golden_d   = first_golden_q;
        first_faulty_d   = first_faulty_q;
        first_syndrome_d = first_syndrome_q;
        fault_class_d    = fault_class_q;

        if (clear) begin
            state_d          = S_IDLE;
            fault_detected_d = 1'b0;
            sample_count_d   = '0;
            mismatch_count_d = '0;
            first_index_d    = '0;
            first_golden_d   = '0;
            first_faulty_d   = '0;
            first_syndrome_d = '0;
            fault_class_d    = 2'b00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_d = S_MONITOR;
                end
                S_MONITOR, S_DETECTED: begin
                    if (accept) begin
                        sample_count_d = sample_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (data_mis || ctrl_mis) begin
                            mismatch_d       = 1'b1;
                            mismatch_count_d = mcount_inc;
                            // Capture only the very first fault; later faults leave it intact.
                            if (!fault_detected_q) begin
                                fault_detected_d = 1'b1;
                                first_index_d    = sample_count_q;
                                first_golden_d   = golden_result;
                                first_faulty_d   = faulty_result;
                                first_syndrome_d = golden_result ^ faulty_result;
                                fault_class_d    = {ctrl_mis, data_mis};
                            end
                            // With THRESH=1 this takes MONITOR straight to HALT.
                            if (mcount_inc >= 8'(THRESH)) state_d = S_HALT;
                            else                          state_d = S_DETECTED;
                        end
                    end
                end
                default: ; // HALT: frozen until clear or rst
            endcase
        end

        halt_req_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            mismatch_q       <= 1'b0;
            fault_detected_q <= 1'b0;
            halt_req_q       <= 1'b0;
            sample_count_q   <= '0;
            mismatch_count_q <= '0;
            first_index_q    <= '0;
            first_golden_q   <= '0;
            first_faulty_q   <= '0;
            first_syndrome_q <= '0;
            fault_class_q    <= 2'b00;
        end else begin
            state_q          <= state_d;
            mismatch_q       <= mismatch_d;
            fault_detected_q <= fault_detected_d;
            halt_req_q       <= halt_req_d;
            sample_count_q   <= sample_count_d;
            mismatch_count_q <= mismatch_count_d;
            first_index_q    <= first_index_d;
            first_golden_q   <= first_golden_d;
            first_faulty_q   <= first_faulty_d;
            first_syndrome_q <= first_syndrome_d;
            fault_class_q    <= fault_class_d;
        end
    end

    assign state          = state_q;
    assign mismatch       = mismatch_q;
    assign fault_detected = fault_detected_q;
    assign halt_req       = halt_req_q;
    assign sample_count   = sample_count_q;
    assign mismatch_count = mismatch_count_q;
    assign first_index    = first_index_q;
    assign first_golden   = first_golden_q;
    assign first_faulty   = first_faulty_q;
    assign first_syndrome = first_syndrome_q;
    assign fault_class    = fault_class_q;

endmodule

// File: tb/tb_fault_detector.sv
// Bench for fault_detector. Two instances share all inputs:
//   u_a: THRESH=4, CNT_W=16 (defaults)
//   u_b: THRESH=1, CNT_W=4  (direct MONITOR->HALT, fast counter wrap)
// A reference model written from the behavioural rules tracks both instances.
module tb_fault_detector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] golden_result = '0;
    logic [31:0] faulty_result = '0;
    logic        golden_zero = 1'b0;
    logic        faulty_zero = 1'b0;
    logic [2:0]  golden_ctrl = '0;
    logic [2:0]  faulty_ctrl = '0;

    logic        a_mis, a_fd, a_halt;
    logic [1:0]  a_state, a_fc;
    logic [15:0] a_cnt, a_fi;
    logic [7:0]  a_mc;
    logic [31:0] a_fg, a_ff, a_fs;

    logic        b_mis, b_fd, b_halt;
    logic [1:0]  b_state, b_fc;
    logic [3:0]  b_cnt, b_fi;
    logic [7:0]  b_mc;
    logic [31:0] b_fg, b_ff, b_fs;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fault_detector #(.THRESH(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .sample_valid(sample_valid),
        .golden_result(golden_result), .faulty_result(faulty_result),
        .golden_zero(golden_zero), .faulty_zero(faulty_zero),
        .golden_ctrl(golden_ctrl), .faulty_ctrl(faulty_ctrl),
        .mismatch(a_mis), .fault_detected(a_fd), .halt_req(a_halt),
        .state(a_state), .sample_count(a_cnt), .mismatch_count(a_mc),
        .first_index(a_fi), .first_golden(a_fg), .first_faulty(a_ff),
        .first_syndrome(a_fs), .fault_class(a_fc)
    );

    fault_detector #(.THRESH(1), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .sample_valid(sample_valid),
        .golden_result(golden_result), .faulty_result(faulty_result),
        .golden_zero(golden_zero), .faulty_zero(faulty_zero),
        .golden_ctrl(golden_ctrl), .faulty_ctrl(faulty_ctrl),
        .mismatch(b_mis), .fault_detected(b_fd), .halt_req(b_halt),
        .state(b_state), .sample_count(b_cnt), .mismatch_count(b_mc),
        .first_index(b_fi), .first_golden(b_fg), .first_faulty(b_ff),
        .first_syndrome(b_fs), .fault_class(b_fc)
    );

    // Observation vectors: all outputs of each instance, indices widened to 16.
    logic [142:0] obs_a, obs_b;
    assign obs_a = {a_mis, a_fd, a_halt, a_state, a_cnt, a_mc, a_fi, a_fg, a_ff, a_fs, a_fc};
    assign obs_b = {b_mis, b_fd, b_halt, b_state, {12'b0, b_cnt}, b_mc, {12'b0, b_fi},
                    b_fg, b_ff, b_fs, b_fc};

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 monitoring, 2 fault seen, 3 halted
    int          thr[2]  = '{4, 1};
    int          modw[2] = '{65536, 16};
    int          m_phase[2];
    int          m_cnt[2];
    int          m_mc[2];
    bit          m_fd[2];
    bit          m_mis[2];
    int          m_fi[2];
    logic [31:0] m_fg[2];
    logic [31:0] m_ff[2];
    int          m_fc[2];

    task automatic model_zero(input int k);
        m_phase[k] = 0; m_cnt[k] = 0; m_mc[k] = 0; m_fd[k] = 0; m_mis[k] = 0;
        m_fi[k] = 0; m_fg[k] = '0; m_ff[k] = '0; m_fc[k] = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit dm, cm;
        dm = (golden_result != faulty_result) || (golden_zero != faulty_zero);
        cm = (golden_ctrl != faulty_ctrl);
        for (int k = 0; k < 2; k++) begin
            if (rst || clear) begin
                model_zero(k);
            end else begin
                m_mis[k] = 0;
                if (m_phase[k] == 0) begin
                    if (enable) m_phase[k] = 1;
                end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
                    if (sample_valid && enable) begin
                        int old_cnt;
                        old_cnt = m_cnt[k];
                        m_cnt[k] = (m_cnt[k] + 1) % modw[k];
                        if (dm || cm) begin
                            if (!m_fd[k]) begin
                                m_fd[k] = 1;
                                m_fi[k] = old_cnt;
                                m_fg[k] = golden_result;
                                m_ff[k] = faulty_result;
                                m_fc[k] = (cm ? 2 : 0) + (dm ? 1 : 0);
                            end
                            if (m_mc[k] < 255) m_mc[k]++;
                            m_mis[k] = 1;
                            m_phase[k] = (m_mc[k] >= thr[k]) ? 3 : 2;
                        end
                    end
                end
            end
        end
    endtask

    function automatic logic [142:0] exp_vec(input int k);
        return {m_mis[k], m_fd[k], (m_phase[k] == 3), 2'(m_phase[k]), 16'(m_cnt[k]),
                8'(m_mc[k]), 16'(m_fi[k]), m_fg[k], m_ff[k], m_fg[k] ^ m_ff[k], 2'(m_fc[k])};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] g, input logic [31:0] f,
                         input logic [2:0] gc, input logic [2:0] fc);
        sample_valid  = v;
        golden_result = g;
        faulty_result = f;
        golden_zero   = (g == 32'd0);
        faulty_zero   = (f == 32'd0);
        golden_ctrl   = gc;
        faulty_ctrl   = fc;
    endtask

    task automatic do_reset_enable();
        rst = 1'b1; clear = 1'b0; enable = 1'b0;
        drive(0, 32'd0, 32'd0, 3'b000, 3'b000);
        tick();
        rst = 1'b0; enable = 1'b1;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (obs_a !== '0) begin
            n_fail++; $display("FAIL reset_a: got %h expected 0", obs_a);
        end
        n_cmp++;
        if (obs_b !== '0) begin
            n_fail++; $display("FAIL reset_b: got %h expected 0", obs_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_matching();
        int pulses;
        pulses = 0;
        do_reset_enable();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h5, 32'h5, 3'b010, 3'b010);
            tick();
            if (a_mis) pulses++;
        end
        drive(0, 32'h5, 32'h5, 3'b010, 3'b010);
        n_cmp++;
        if (a_state !== 2'b01 || a_cnt !== 16'd5 || a_fd !== 1'b0 || pulses != 0) begin
            n_fail++;
            $display("FAIL matching: got state=%b cnt=%0d fd=%b pulses=%0d expected state=01 cnt=5 fd=0 pulses=0",
                     a_state, a_cnt, a_fd, pulses);
        end
        n_cmp++;
        if (obs_a !== exp_vec(0)) begin
            n_fail++; $display("FAIL matching_model: got %h expected %h", obs_a, exp_vec(0));
        end
    endtask

    task automatic test_data_fault();
        do_reset_enable();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h7, 32'h7, 3'b010, 3'b010);
            tick();
        end
        drive(1, 32'h0000000C, 32'h00000004, 3'b010, 3'b010);
        tick();
        drive(0, 32'h0, 32'h0, 3'b000, 3'b000);
        n_cmp++;
        if (a_mis !== 1'b1 || a_state !== 2'b10 || a_fi !== 16'd3 ||
            a_fs !== 32'h8 || a_fc !== 2'b01 || a_fd !== 1'b1) begin
            n_fail++;
            $display("FAIL data_fault_a: got mis=%b state=%b idx=%0d syn=%h class=%b expected 1 10 3 00000008 01",
                     a_mis, a_state, a_fi, a_fs, a_fc);
        end
        // THRESH=1 instance: direct to HALT, capture still taken
        n_cmp++;
        if (b_state !== 2'b11 || b_halt !== 1'b1 || b_fi !== 4'd3 || b_fc !== 2'b01 ||
            b_fg !== 32'hC || b_ff !== 32'h4) begin
            n_fail++;
            $display("FAIL data_fault_b: got state=%b halt=%b idx=%0d class=%b g=%h f=%h expected 11 1 3 01 c 4",
                     b_state, b_halt, b_fi, b_fc, b_fg, b_ff);
        end
        tick();
        n_cmp++;
        if (a_mis !== 1'b0) begin
            n_fail++; $display("FAIL pulse_width: got %b expected 0", a_mis);
        end
    endtask

    task automatic test_ctrl_fault();
        do_reset_enable();
        drive(1, 32'h5, 32'h5, 3'b010, 3'b000);
        tick();
        n_cmp++;
        if (a_fc !== 2'b10 || a_fi !== 16'd0 || a_fs !== 32'd0) begin
            n_fail++;
            $display("FAIL ctrl_class: got class=%b idx=%0d syn=%h expected 10 0 0", a_fc, a_fi, a_fs);
        end
        drive(1, 32'h11, 32'h22, 3'b010, 3'b010);
        tick();
        drive(0, 32'h0, 32'h0, 3'b000, 3'b000);
        n_cmp++;
        if (a_fc !== 2'b10 || a_fg !== 32'h5 || a_ff !== 32'h5 || a_fi !== 16'd0 ||
            a_mc !== 8'd2 || a_mis !== 1'b1) begin
            n_fail++;
            $display("FAIL capture_hold: got class=%b g=%h f=%h idx=%0d mc=%0d mis=%b expected 10 5 5 0 2 1",
                     a_fc, a_fg, a_ff, a_fi, a_mc, a_mis);
        end
    endtask

    task automatic test_back_to_back_halt();
        int pulses;
        pulses = 0;
        do_reset_enable();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h100 + 32'(i), 32'h0, 3'b001, 3'b001);
            tick();
            if (a_mis === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 4 || a_state !== 2'b11 || a_halt !== 1'b1 || a_mc !== 8'd4) begin
            n_fail++;
            $display("FAIL halt_entry: got pulses=%0d state=%b halt=%b mc=%0d expected 4 11 1 4",
                     pulses, a_state, a_halt, a_mc);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h1, 32'h2, 3'b001, 3'b001);
            tick();
        end
        drive(0, 32'h0, 32'h0, 3'b000, 3'b000);
        n_cmp++;
        if (a_cnt !== 16'd4 || a_mc !== 8'd4 || a_state !== 2'b11 || a_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_frozen: got cnt=%0d mc=%0d state=%b mis=%b expected 4 4 11 0",
                     a_cnt, a_mc, a_state, a_mis);
        end
        // rst while halted clears everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (obs_a !== '0 || obs_b !== '0) begin
            n_fail++; $display("FAIL halt_reset: got a=%h b=%h expected 0", obs_a, obs_b);
        end
    endtask

    task automatic test_clear_priority();
        do_reset_enable();
        drive(1, 32'h3, 32'h9, 3'b000, 3'b000);
        tick();
        clear = 1'b1;
        drive(1, 32'hA, 32'hB, 3'b000, 3'b000);
        tick();
        clear = 1'b0;
        drive(0, 32'h0, 32'h0, 3'b000, 3'b000);
        n_cmp++;
        if (obs_a !== '0) begin
            n_fail++; $display("FAIL clear_same_cycle: got %h expected 0", obs_a);
        end
        // enable still high: leaves IDLE next cycle, nothing accepted on that cycle
        drive(1, 32'h1, 32'h2, 3'b000, 3'b000);
        tick();
        n_cmp++;
        if (a_state !== 2'b01 || a_cnt !== 16'd0 || a_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_exit: got state=%b cnt=%0d mis=%b expected 01 0 0", a_state, a_cnt, a_mis);
        end
    endtask

    task automatic test_enable_hold();
        do_reset_enable();
        drive(1, 32'h5, 32'h5, 3'b010, 3'b010);
        tick();
        enable = 1'b0;
        drive(1, 32'h5, 32'h6, 3'b010, 3'b010);
        tick();
        tick();
        n_cmp++;
        if (a_state !== 2'b01 || a_cnt !== 16'd1 || a_mc !== 8'd0 || a_mis !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_hold: got state=%b cnt=%0d mc=%0d mis=%b expected 01 1 0 0",
                     a_state, a_cnt, a_mc, a_mis);
        end
        enable = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset_enable();
        for (int i = 0; i < 17; i++) begin
            drive(1, 32'h5, 32'h5, 3'b010, 3'b010);
            tick();
        end
        drive(0, 32'h0, 32'h0, 3'b000, 3'b000);
        n_cmp++;
        if (b_cnt !== 4'd1 || b_state !== 2'b01 || a_cnt !== 16'd17) begin
            n_fail++;
            $display("FAIL wrap: got b_cnt=%0d b_state=%b a_cnt=%0d expected 1 01 17", b_cnt, b_state, a_cnt);
        end
    endtask

    task automatic test_random();
        do_reset_enable();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] g;
            g = $urandom;
            rst    = ($urandom_range(0, 199) == 0);
            clear  = ($urandom_range(0, 39) == 0);
            enable = ($urandom_range(0, 9) != 0);
            sample_valid  = ($urandom_range(0, 3) != 0);
            golden_result = g;
            faulty_result = ($urandom_range(0, 9) == 0) ? (g ^ (32'd1 << $urandom_range(0, 31))) : g;
            golden_zero   = $urandom_range(0, 1);
            faulty_zero   = ($urandom_range(0, 19) == 0) ? ~golden_zero : golden_zero;
            golden_ctrl   = 3'($urandom_range(0, 7));
            faulty_ctrl   = ($urandom_range(0, 14) == 0) ? 3'($urandom_range(0, 7)) : golden_ctrl;
            tick();
            n_cmp++;
            if (obs_a !== exp_vec(0)) begin
                n_fail++; $display("FAIL random_a[%0d]: got %h expected %h", i, obs_a, exp_vec(0));
            end
            n_cmp++;
            if (obs_b !== exp_vec(1)) begin
                n_fail++; $display("FAIL random_b[%0d]: got %h expected %h", i, obs_b, exp_vec(1));
            end
        end
        rst = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) model_zero(k);
        test_reset();
        test_matching();
        test_data_fault();
        test_ctrl_fault();
        test_back_to_back_halt();
        test_clear_priority();
        test_enable_hold();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
